// File: rtl/wb8_pkg.sv
// Shared definitions for the 8-bit Wishbone RAM arbiter: default bus widths,
// arbiter state encoding and the round-robin pick rule.
package wb8_pkg;

    localparam int unsigned WB8_ADDR_WIDTH = 10;
    localparam int unsigned WB8_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_GAP  = 2'd3
    } wb8_state_e;

    // Round-robin pick: a lone requester wins; on a tie the master not served last wins.
    function automatic wb8_state_e wb8_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return last ? ST_GNT0 : ST_GNT1;
        end
        if (req0) begin
            return ST_GNT0;
        end
        if (req1) begin
            return ST_GNT1;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/ram_arbiter_wb8.sv
// Two-master round-robin arbiter in front of one registered-ack 8-bit Wishbone RAM.
// Single-beat transfers are serialised with one idle strobe cycle after every ack.
import wb8_pkg::*;

module ram_arbiter_wb8 #(
    parameter int unsigned ADDR_WIDTH = WB8_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WB8_DATA_WIDTH
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  M0_STB_I,
    input  logic                  M0_WE_I,
    input  logic [ADDR_WIDTH-1:0] M0_ADR_I,
    input  logic [DATA_WIDTH-1:0] M0_DAT_I,
    output logic [DATA_WIDTH-1:0] M0_DAT_O,
    output logic                  M0_ACK_O,
    input  logic                  M1_STB_I,
    input  logic                  M1_WE_I,
    input  logic [ADDR_WIDTH-1:0] M1_ADR_I,
    input  logic [DATA_WIDTH-1:0] M1_DAT_I,
    output logic [DATA_WIDTH-1:0] M1_DAT_O,
    output logic                  M1_ACK_O,
    output logic                  S_STB_O,
    output logic                  S_WE_O,
    output logic [ADDR_WIDTH-1:0] S_ADR_O,
    output logic [DATA_WIDTH-1:0] S_DAT_O,
    input  logic [DATA_WIDTH-1:0] S_DAT_I,
    input  logic                  S_ACK_I
);

    wb8_state_e state_q, state_d;
    logic       last_q,  last_d;

    // State and last-served registers; reset makes M0 win the first tie.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic and slave-side request mux.
    // GAP arbitrates directly so the strobe is low for exactly one cycle between grants.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        S_STB_O = 1'b0;
        S_WE_O  = 1'b0;
        S_ADR_O = '0;
        S_DAT_O = '0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                state_d = wb8_pick(M0_STB_I, M1_STB_I, last_q);
            end
            ST_GNT0: begin
                S_STB_O = 1'b1;
                S_WE_O  = M0_WE_I;
                S_ADR_O = M0_ADR_I;
                S_DAT_O = M0_DAT_I;
                if (!M0_STB_I) begin
                    state_d = ST_IDLE;
                end else if (S_ACK_I) begin
                    last_d  = 1'b0;
                    state_d = ST_GAP;
                end
            end
            ST_GNT1: begin
                S_STB_O = 1'b1;
                S_WE_O  = M1_WE_I;
                S_ADR_O = M1_ADR_I;
                S_DAT_O = M1_DAT_I;
                if (!M1_STB_I) begin
                    state_d = ST_IDLE;
                end else if (S_ACK_I) begin
                    last_d  = 1'b1;
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Acks only reach the granted, still-requesting master; read data is broadcast.
    always_comb begin
        M0_ACK_O = S_ACK_I && (state_q == ST_GNT0) && M0_STB_I;
        M1_ACK_O = S_ACK_I && (state_q == ST_GNT1) && M1_STB_I;
        M0_DAT_O = S_DAT_I;
        M1_DAT_O = S_DAT_I;
    end

endmodule

// File: tb/tb_ram_arbiter_wb8.sv
// Bench for ram_arbiter_wb8: 1 KiB registered-ack RAM slave, directed scenarios plus
// randomized two-master traffic, scoreboard of expected acks checked by a monitor.
module tb_ram_arbiter_wb8;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          RST_I;
    logic          M0_STB_I, M0_WE_I, M1_STB_I, M1_WE_I;
    logic [AW-1:0] M0_ADR_I, M1_ADR_I, S_ADR_O;
    logic [DW-1:0] M0_DAT_I, M1_DAT_I, M0_DAT_O, M1_DAT_O, S_DAT_O, S_DAT_I;
    logic          M0_ACK_O, M1_ACK_O, S_STB_O, S_WE_O, S_ACK_I;

    always #5 clk = ~clk;

    ram_arbiter_wb8 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK_I(clk), .RST_I(RST_I),
        .M0_STB_I(M0_STB_I), .M0_WE_I(M0_WE_I), .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I),
        .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O),
        .M1_STB_I(M1_STB_I), .M1_WE_I(M1_WE_I), .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I),
        .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O),
        .S_STB_O(S_STB_O), .S_WE_O(S_WE_O), .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O),
        .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I)
    );

    // Registered-ack RAM slave: ack register follows STB, so it stays set while STB is held.
    logic [DW-1:0] ram [0:1023];
    logic          ack_r;
    logic [DW-1:0] rdat_r;
    logic          preloaded = 1'b0;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= i[7:0];
            preloaded <= 1'b1;
        end
        if (RST_I) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= S_STB_O;
            if (S_STB_O) begin
                if (S_WE_O) ram[S_ADR_O] <= S_DAT_O;
                rdat_r <= ram[S_ADR_O];
            end
        end
    end
    assign S_ACK_I = ack_r & S_STB_O;
    assign S_DAT_I = rdat_r;

    // Reference model and scoreboard
    typedef struct {
        int       m;
        bit       we;
        bit [9:0] adr;
        bit [7:0] dat;
    } txn_t;

    txn_t     q0[$], q1[$], expq[$];
    bit [7:0] ref_mem [0:1023];
    bit       model_last;
    int       checks = 0;
    int       failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic serve(input txn_t t);
        txn_t e;
        e = t;
        if (t.we) ref_mem[t.adr] = t.dat;
        else e.dat = ref_mem[t.adr];
        expq.push_back(e);
        model_last = (t.m != 0);
    endtask

    // Transaction-level order: both masters re-request right after each ack, so while both
    // lists have work the grant goes to whoever was not served last.
    task automatic plan();
        int i0 = 0;
        int i1 = 0;
        while (i0 < q0.size() || i1 < q1.size()) begin
            bit pick1;
            if (i0 < q0.size() && i1 < q1.size()) pick1 = (model_last == 1'b0);
            else pick1 = (i1 < q1.size());
            if (pick1) begin serve(q1[i1]); i1++; end
            else begin serve(q0[i0]); i0++; end
        end
    endtask

    task automatic drive_m0();
        foreach (q0[k]) begin
            int n = 0;
            M0_STB_I = 1'b1; M0_WE_I = q0[k].we; M0_ADR_I = q0[k].adr; M0_DAT_I = q0[k].dat;
            do begin @(negedge clk); n++; end while (!M0_ACK_O && n < 40);
            chk("m0_ack_wait", M0_ACK_O, 1);
            @(posedge clk); #1;
        end
        M0_STB_I = 1'b0; M0_WE_I = 1'b0;
    endtask

    task automatic drive_m1();
        foreach (q1[k]) begin
            int n = 0;
            M1_STB_I = 1'b1; M1_WE_I = q1[k].we; M1_ADR_I = q1[k].adr; M1_DAT_I = q1[k].dat;
            do begin @(negedge clk); n++; end while (!M1_ACK_O && n < 40);
            chk("m1_ack_wait", M1_ACK_O, 1);
            @(posedge clk); #1;
        end
        M1_STB_I = 1'b0; M1_WE_I = 1'b0;
    endtask

    task automatic run_both();
        plan();
        fork
            drive_m0();
            drive_m1();
        join
        q0.delete();
        q1.delete();
    endtask

    function automatic txn_t mk(input int m, input bit we, input bit [9:0] adr, input bit [7:0] dat);
        txn_t t;
        t.m = m; t.we = we; t.adr = adr; t.dat = dat;
        return t;
    endfunction

    task automatic mon_ack(input int m, input logic [7:0] dat);
        txn_t e;
        if (expq.size() == 0) begin
            chk("spurious_ack", 1, 0);
        end else begin
            e = expq.pop_front();
            chk("ack_master", m, e.m);
            chk("ack_addr", int'(S_ADR_O), int'(e.adr));
            chk("ack_we", int'(S_WE_O), int'(e.we));
            if (!e.we) chk("rd_data", int'(dat), int'(e.dat));
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (M0_ACK_O && M1_ACK_O) chk("dual_ack", 1, 0);
            if (M0_ACK_O) mon_ack(0, M0_DAT_O);
            if (M1_ACK_O) mon_ack(1, M1_DAT_O);
        end
    endtask

    task automatic watch_gaps(input int nacks);
        int low_run = 0;
        bit seen_high = 1'b0;
        int acks = 0;
        for (int c = 0; c < 80 && acks < nacks; c++) begin
            @(negedge clk);
            if (S_STB_O) begin
                if (seen_high && low_run > 0) chk("gap_len", low_run, 1);
                low_run = 0;
                seen_high = 1'b1;
            end else if (seen_high) begin
                low_run++;
            end
            if (M0_ACK_O || M1_ACK_O) acks++;
        end
        chk("t3_ack_count", acks, nacks);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST_I = 1'b1;
        M0_STB_I = 1'b0; M0_WE_I = 1'b0; M0_ADR_I = '0; M0_DAT_I = '0;
        M1_STB_I = 1'b0; M1_WE_I = 1'b0; M1_ADR_I = '0; M1_DAT_I = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = i[7:0];
        model_last = 1'b1;
        fork monitor(); join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stb", S_STB_O, 0);
        chk("rst_ack0", M0_ACK_O, 0);
        chk("rst_ack1", M1_ACK_O, 0);
        chk("rst_adr", int'(S_ADR_O), 0);
        @(posedge clk); #1;
        RST_I = 1'b0;

        // 1: lone M0 read with cycle-exact latency
        q0.push_back(mk(0, 1'b0, 10'h005, 8'h00));
        plan();
        q0.delete();
        M0_STB_I = 1'b1; M0_WE_I = 1'b0; M0_ADR_I = 10'h005;
        @(negedge clk); chk("t1_stb_idle", S_STB_O, 0);
        @(negedge clk); chk("t1_stb_gnt", S_STB_O, 1); chk("t1_ack_early", M0_ACK_O, 0);
        @(negedge clk); chk("t1_ack", M0_ACK_O, 1); chk("t1_dat", int'(M0_DAT_O), 5);
        chk("t1_m1_ack", M1_ACK_O, 0);
        @(posedge clk); #1;
        M0_STB_I = 1'b0;
        @(negedge clk); chk("t1_gap_stb", S_STB_O, 0);
        @(posedge clk); #1;

        // 2: tie from reset, M0 writes then M1 reads the same location
        RST_I = 1'b1;
        @(posedge clk); #1;
        RST_I = 1'b0;
        model_last = 1'b1;
        q0.push_back(mk(0, 1'b1, 10'h3FF, 8'hA5));
        q1.push_back(mk(1, 1'b0, 10'h3FF, 8'h00));
        run_both();

        // 3: both masters saturate for six transfers
        for (int k = 0; k < 3; k++) begin
            q0.push_back(mk(0, 1'b0, 10'h050 + 10'(k), 8'h00));
            q1.push_back(mk(1, 1'b0, 10'h060 + 10'(k), 8'h00));
        end
        fork
            run_both();
            watch_gaps(6);
        join

        // 4: M1 aborts in its grant while M0 waits
        M1_STB_I = 1'b1; M1_WE_I = 1'b0; M1_ADR_I = 10'h020;
        @(posedge clk); #1;
        chk("t4_gnt1_stb", S_STB_O, 1);
        M1_STB_I = 1'b0;
        q0.push_back(mk(0, 1'b0, 10'h030, 8'h00));
        plan();
        q0.delete();
        M0_STB_I = 1'b1; M0_WE_I = 1'b0; M0_ADR_I = 10'h030;
        @(negedge clk); chk("t4_no_m1_ack", M1_ACK_O, 0);
        @(posedge clk); #1;
        chk("t4_idle_stb", S_STB_O, 0);
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!M0_ACK_O && n < 40);
            chk("t4_m0_ack", M0_ACK_O, 1);
        end
        @(posedge clk); #1;
        M0_STB_I = 1'b0;

        // 5: reset during GNT0, then a tie must go to M0
        @(posedge clk); #1;
        M0_STB_I = 1'b1; M0_WE_I = 1'b0; M0_ADR_I = 10'h040;
        @(posedge clk); #1;
        chk("t5_gnt0_stb", S_STB_O, 1);
        RST_I = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_stb", S_STB_O, 0);
        chk("t5_rst_ack0", M0_ACK_O, 0);
        chk("t5_rst_ack1", M1_ACK_O, 0);
        RST_I = 1'b0;
        M0_STB_I = 1'b0;
        model_last = 1'b1;
        q0.push_back(mk(0, 1'b0, 10'h041, 8'h00));
        q1.push_back(mk(1, 1'b0, 10'h042, 8'h00));
        run_both();

        // 6: back-to-back M0 writes then reads
        for (int k = 0; k < 4; k++) q0.push_back(mk(0, 1'b1, 10'h010 + 10'(k), 8'($urandom)));
        for (int k = 0; k < 4; k++) q0.push_back(mk(0, 1'b0, 10'h010 + 10'(k), 8'h00));
        run_both();

        // Randomized mixed traffic on a small address window
        for (int r = 0; r < 25; r++) begin
            int n0 = $urandom_range(0, 4);
            int n1 = $urandom_range(0, 4);
            for (int k = 0; k < n0; k++)
                q0.push_back(mk(0, 1'($urandom_range(0, 1)), 10'h100 + 10'($urandom_range(0, 15)), 8'($urandom)));
            for (int k = 0; k < n1; k++)
                q1.push_back(mk(1, 1'($urandom_range(0, 1)), 10'h100 + 10'($urandom_range(0, 15)), 8'($urandom)));
            run_both();
        end

        repeat (10) @(negedge clk);
        chk("exp_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
